tap_controller: RTL
===================

# tap_controller

Full IEEE 1149.1-style TAP controller, generalising the 3-state TAP fragment to all 16 TAP states. Adds an instruction register of parametrised width, a BYPASS register, a 32-bit IDCODE register, and a parametrised USER data register with a parallel capture/update port. Sits between the JTAG pins and on-chip debug/test logic. Exposes the current state on an observation bus for bench and silicon debug.

## Interface
- `IR_WIDTH`, 4: instruction register width, ≥2.
- `DR_WIDTH`, 8: USER data register width, ≥1.
- `IDCODE_VALUE`, 32'h1000_0001: value captured by IDCODE; bit 0 must be 1.
- `IDCODE_INSTR`, 1: IDCODE opcode; also the instruction after reset / Test_Logic_Reset.
- `USER_INSTR`, 2: opcode selecting the USER register. All-ones = BYPASS. Any other undefined opcode also selects BYPASS.

Ports:
- `clk` in 1: TCK; all state changes on the rising edge.
- `TRST_n` in 1: asynchronous, active-low reset.
- `TMS` in 1: mode select, sampled on the rising edge.
- `TDI` in 1: serial data in.
- `TDO` out 1: serial data out.
- `tdo_en` out 1: high while in Shift_DR or Shift_IR.
- `state_obs` out 4: current state encoding.
- `ir_q` out IR_WIDTH: active instruction.
- `user_capture` in DR_WIDTH: parallel value loaded in Capture_DR when USER is active.
- `user_q` out DR_WIDTH: USER register parallel output.
- `user_update` out 1: one-cycle pulse when user_q is written.
- `tlr` out 1: high while in Test_Logic_Reset.

## Operation
- State encoding: 0 Test_Logic_Reset, 1 Run_Test_Idle, 2 Select_DR_Scan, 3 Capture_DR, 4 Shift_DR, 5 Exit1_DR, 6 Pause_DR, 7 Exit2_DR, 8 Update_DR, 9 Select_IR_Scan, 10 Capture_IR, 11 Shift_IR, 12 Exit1_IR, 13 Pause_IR, 14 Exit2_IR, 15 Update_IR.
- Transitions, written as state: next on TMS=0 / next on TMS=1:
  - TLR: RTI / TLR. RTI: RTI / SelDR. SelDR: CapDR / SelIR. SelIR: CapIR / TLR.
  - CapxR: ShiftxR / Exit1xR. ShiftxR: ShiftxR / Exit1xR.
  - Exit1xR: PausexR / UpdatexR. PausexR: PausexR / Exit2xR. Exit2xR: ShiftxR / UpdatexR.
  - UpdatexR: RTI / SelDR.
- Five consecutive TMS=1 edges reach TLR from any state.
- Capture_IR: IR shift register loads {0…0,01}.
- Shift_xR: the selected shift register loads {TDI, sr[W-1:1]}, LSB first. TDO = sr[0] of the selected register.
- Update_IR: ir_q ← IR shift register.
- DR select by ir_q: IDCODE_INSTR → 32-bit IDCODE; USER_INSTR → DR_WIDTH USER register; else → 1-bit BYPASS.
- Capture_DR loads IDCODE_VALUE, user_capture, or 0 (BYPASS) into the selected register.
- Update_DR with USER active: user_q ← USER shift register and user_update pulses. Other instructions leave user_q untouched.
- In TLR, ir_q ← IDCODE_INSTR every cycle. user_q is not cleared by TLR.

## Timing
- Reset (TRST_n low, asynchronous) sets: state TLR; state_obs 0; tlr 1; ir_q IDCODE_INSTR; all shift registers 0; user_q 0; user_update 0; tdo_en 0.
- After TRST_n deasserts, the first rising edge evaluates TMS from TLR.
- state_obs, tlr and tdo_en decode the state register combinationally, so they change in the same cycle as the state.
- TDO is combinational from sr[0] and the current selection. TDO = 0 when tdo_en = 0.
- Capture, shift and update actions occur on the rising edge that leaves that state.
- user_update is high for exactly one clk, on the cycle after the edge leaving Update_DR, aligned with the new user_q.
- ir_q changes on the edge leaving Update_IR. DR selection for the next Capture_DR uses the new ir_q.
- TRST_n asserted mid-shift aborts immediately: partial shift data is discarded and user_q holds its reset value 0.

## Structure
- Package `tap_pkg`: 4-bit state localparams (encoding above) and the BYPASS all-ones opcode helper.
- Sub-module `tap_fsm`: state register plus next-state logic, inputs clk/TRST_n/TMS, output state.
- Top level holds the IR, DR and BYPASS shift registers, DR select mux and TDO mux.

## Test plan
- Reset, then TMS=0 → state_obs 1. Any state plus 5× TMS=1 → state_obs 0, ir_q=IDCODE_INSTR.
- From RTI, scan DR with 32 shift cycles, TDI=0 → TDO serial LSB-first = 32'h1000_0001.
- Load IR=4'hF (BYPASS); shift DR with TDI pattern 1,0,1,1 → TDO = 0,1,0,1 (one-cycle delay, leading captured 0).
- Load IR=USER_INSTR with user_capture=8'hA5, shift 8'h3C in → TDO = A5 LSB-first; after Update_DR, user_q=8'h3C and user_update is one pulse.
- Capture_IR then shift IR_WIDTH bits → TDO = 1,0,0,0. Pause_IR/Exit2_IR round trip resumes shift without data loss.
- TRST_n low during Shift_DR of USER → state_obs 0 and user_q 0 immediately, no user_update.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared TAP definitions: 16-state encoding, DR selection and opcode helpers.
package tap_pkg;

    localparam int unsigned TAP_STATE_W = 4;
    localparam int unsigned IDCODE_W    = 32;

    typedef enum logic [TAP_STATE_W-1:0] {
        StTestLogicReset = 4'd0,
        StRunTestIdle    = 4'd1,
        StSelectDrScan   = 4'd2,
        StCaptureDr      = 4'd3,
        StShiftDr        = 4'd4,
        StExit1Dr        = 4'd5,
        StPauseDr        = 4'd6,
        StExit2Dr        = 4'd7,
        StUpdateDr       = 4'd8,
        StSelectIrScan   = 4'd9,
        StCaptureIr      = 4'd10,
        StShiftIr        = 4'd11,
        StExit1Ir        = 4'd12,
        StPauseIr        = 4'd13,
        StExit2Ir        = 4'd14,
        StUpdateIr       = 4'd15
    } tap_state_e;

    typedef enum logic [1:0] {
        DrBypass = 2'd0,
        DrIdcode = 2'd1,
        DrUser   = 2'd2
    } dr_sel_e;

    // All-ones opcode of the given IR width (widths up to 32).
    function automatic logic [31:0] bypass_opcode(input int unsigned width);
        logic [32:0] ones;
        ones = (33'd1 << width) - 33'd1;
        return ones[31:0];
    endfunction

endpackage

// File: rtl/tap_fsm.sv
// TAP state register and TMS-driven next-state logic for all 16 states.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       clk,
    input  logic       TRST_n,
    input  logic       TMS,
    output tap_state_e state
);

    tap_state_e state_q, state_d;

    always_ff @(posedge clk or negedge TRST_n) begin
        if (!TRST_n) begin
            state_q <= StTestLogicReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StTestLogicReset: state_d = TMS ? StTestLogicReset : StRunTestIdle;
            StRunTestIdle:    state_d = TMS ? StSelectDrScan   : StRunTestIdle;
            StSelectDrScan:   state_d = TMS ? StSelectIrScan   : StCaptureDr;
            StCaptureDr:      state_d = TMS ? StExit1Dr        : StShiftDr;
            StShiftDr:        state_d = TMS ? StExit1Dr        : StShiftDr;
            StExit1Dr:        state_d = TMS ? StUpdateDr       : StPauseDr;
            StPauseDr:        state_d = TMS ? StExit2Dr        : StPauseDr;
            StExit2Dr:        state_d = TMS ? StUpdateDr       : StShiftDr;
            StUpdateDr:       state_d = TMS ? StSelectDrScan   : StRunTestIdle;
            StSelectIrScan:   state_d = TMS ? StTestLogicReset : StCaptureIr;
            StCaptureIr:      state_d = TMS ? StExit1Ir        : StShiftIr;
            StShiftIr:        state_d = TMS ? StExit1Ir        : StShiftIr;
            StExit1Ir:        state_d = TMS ? StUpdateIr       : StPauseIr;
            StPauseIr:        state_d = TMS ? StExit2Ir        : StPauseIr;
            StExit2Ir:        state_d = TMS ? StUpdateIr       : StShiftIr;
            StUpdateIr:       state_d = TMS ? StSelectDrScan   : StRunTestIdle;
            default:          state_d = StTestLogicReset;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP: FSM plus IR, IDCODE, USER and BYPASS registers and TDO mux.
module tap_controller
    import tap_pkg::*;
#(
    parameter int unsigned            IR_WIDTH     = 4,
    parameter int unsigned            DR_WIDTH     = 8,
    parameter logic [31:0]            IDCODE_VALUE = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0]    IDCODE_INSTR = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]    USER_INSTR   = IR_WIDTH'(2)
) (
    input  logic                clk,
    input  logic                TRST_n,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                tdo_en,
    output logic [3:0]          state_obs,
    output logic [IR_WIDTH-1:0] ir_q,
    input  logic [DR_WIDTH-1:0] user_capture,
    output logic [DR_WIDTH-1:0] user_q,
    output logic                user_update,
    output logic                tlr
);

    localparam logic [31:0]         BYPASS_OP_FULL = bypass_opcode(IR_WIDTH);
    localparam logic [IR_WIDTH-1:0] BYPASS_OP      = BYPASS_OP_FULL[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE     = IR_WIDTH'(1);

    tap_state_e state;

    tap_fsm u_fsm (
        .clk    (clk),
        .TRST_n (TRST_n),
        .TMS    (TMS),
        .state  (state)
    );

    logic [IR_WIDTH-1:0] ir_sr_q;
    logic [IR_WIDTH-1:0] ir_reg_q;
    logic [IDCODE_W-1:0] idcode_sr_q;
    logic [DR_WIDTH-1:0] user_sr_q;
    logic [DR_WIDTH-1:0] user_reg_q;
    logic                bypass_sr_q;
    logic                user_update_q;

    // One extra bit on top so the same slice works down to a 1-bit register.
    logic [IR_WIDTH:0]   ir_shift;
    logic [IDCODE_W:0]   idcode_shift;
    logic [DR_WIDTH:0]   user_shift;

    assign ir_shift     = {TDI, ir_sr_q};
    assign idcode_shift = {TDI, idcode_sr_q};
    assign user_shift   = {TDI, user_sr_q};

    dr_sel_e dr_sel;

    always_comb begin
        dr_sel = DrBypass;
        if (ir_reg_q == BYPASS_OP) begin
            dr_sel = DrBypass;
        end else if (ir_reg_q == IDCODE_INSTR) begin
            dr_sel = DrIdcode;
        end else if (ir_reg_q == USER_INSTR) begin
            dr_sel = DrUser;
        end
    end

    always_ff @(posedge clk or negedge TRST_n) begin
        if (!TRST_n) begin
            ir_sr_q       <= '0;
            ir_reg_q      <= IDCODE_INSTR;
            idcode_sr_q   <= '0;
            user_sr_q     <= '0;
            user_reg_q    <= '0;
            bypass_sr_q   <= 1'b0;
            user_update_q <= 1'b0;
        end else begin
            user_update_q <= 1'b0;
            case (state)
                StTestLogicReset: ir_reg_q <= IDCODE_INSTR;
                StCaptureIr:      ir_sr_q  <= IR_CAPTURE;
                StShiftIr:        ir_sr_q  <= ir_shift[IR_WIDTH:1];
                StUpdateIr:       ir_reg_q <= ir_sr_q;
                StCaptureDr: begin
                    case (dr_sel)
                        DrIdcode: idcode_sr_q <= IDCODE_VALUE;
                        DrUser:   user_sr_q   <= user_capture;
                        default:  bypass_sr_q <= 1'b0;
                    endcase
                end
                StShiftDr: begin
                    case (dr_sel)
                        DrIdcode: idcode_sr_q <= idcode_shift[IDCODE_W:1];
                        DrUser:   user_sr_q   <= user_shift[DR_WIDTH:1];
                        default:  bypass_sr_q <= TDI;
                    endcase
                end
                StUpdateDr: begin
                    if (dr_sel == DrUser) begin
                        user_reg_q    <= user_sr_q;
                        user_update_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state == StShiftIr) begin
            TDO = ir_sr_q[0];
        end else if (state == StShiftDr) begin
            case (dr_sel)
                DrIdcode: TDO = idcode_sr_q[0];
                DrUser:   TDO = user_sr_q[0];
                default:  TDO = bypass_sr_q;
            endcase
        end
    end

    assign tdo_en      = (state == StShiftDr) || (state == StShiftIr);
    assign tlr         = (state == StTestLogicReset);
    assign state_obs   = state;
    assign ir_q        = ir_reg_q;
    assign user_q      = user_reg_q;
    assign user_update = user_update_q;

endmodule
